// File: rtl/input_conditioner.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// input_conditioner
//
// Purpose:
//   Conditions the board's raw pushbuttons and slide switches before they
//   reach the system PIO inputs. Every bit is brought onto clk_clk through a
//   two-flop synchronizer. Each pushbutton bit is then debounced by its own
//   counter. The keys are converted to active-high "pressed" bits. The block
//   also generates a one-cycle press pulse and a sticky press flag per
//   button, which software can poll.
//
// Build option:
//   SWITCH_DEBOUNCE_EN  - when defined, the slide switches get the same
//                         per-bit debounce counters as the keys.
//                         When undefined, the switches are only synchronized.
//                         In that case switches_export is the second
//                         synchronizer flop.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive stable cycles before a debounced bit changes (>= 2)
//   CNT_W            per-bit counter width, must hold DEBOUNCE_CYCLES-1
//   KEY_ACTIVE_LOW   1: key_raw is inverted after synchronization
//
// Ports:
//   clk_clk             in   1   system clock
//   reset_reset_n       in   1   asynchronous active-low reset
//                                (deassertion is synchronized externally)
//   key_raw             in   4   raw pushbutton pins, asynchronous
//   sw_raw              in  10   raw slide switch pins, asynchronous
//   event_clear         in   4   per-bit write-1-to-clear for press_event
//   pushbuttons_export  out  4   debounced pressed state (1 = pressed)
//   switches_export     out 10   switch state (debounced when SWITCH_DEBOUNCE_EN)
//   press_pulse         out  4   one-cycle pulse on each debounced press
//   press_event         out  4   sticky press flags
// -----------------------------------------------------------------------------
module input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20,
  parameter bit          KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic [3:0]  key_raw,
  input  logic [9:0]  sw_raw,
  input  logic [3:0]  event_clear,
  output logic [3:0]  pushbuttons_export,
  output logic [9:0]  switches_export,
  output logic [3:0]  press_pulse,
  output logic [3:0]  press_event
);

  localparam int unsigned N_KEY = 4;
  localparam int unsigned N_SW  = 10;

`ifdef SWITCH_DEBOUNCE_EN
  localparam int unsigned N_DB = N_KEY + N_SW;
`else
  localparam int unsigned N_DB = N_KEY;
`endif

  // The last count value before a debounced bit is allowed to change.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // Two-flop synchronizers.
  // These flops reset to 0, like everything else in this block. For an
  // active-low key, a 0 reads as "pressed". As a result, a released key looks
  // pressed for the first two cycles after reset. DEBOUNCE_CYCLES of 3 or
  // more filters out that transient. A key that is held through reset is
  // already at its synchronized level. It therefore qualifies after only
  // DEBOUNCE_CYCLES edges.
  // ---------------------------------------------------------------------------
  logic [N_KEY-1:0] key_meta_q, key_meta_d;
  logic [N_KEY-1:0] key_sync_q, key_sync_d;
  logic [N_SW-1:0]  sw_meta_q,  sw_meta_d;
  logic [N_SW-1:0]  sw_sync_q,  sw_sync_d;

  always_comb begin
    key_meta_d = key_raw;
    key_sync_d = key_meta_q;
    sw_meta_d  = sw_raw;
    sw_sync_d  = sw_meta_q;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      key_meta_q <= '0;
      key_sync_q <= '0;
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
    end else begin
      key_meta_q <= key_meta_d;
      key_sync_q <= key_sync_d;
      sw_meta_q  <= sw_meta_d;
      sw_sync_q  <= sw_sync_d;
    end
  end

  // Polarity correction is applied after the second flop.
  logic [N_KEY-1:0] key_level;
  assign key_level = KEY_ACTIVE_LOW ? ~key_sync_q : key_sync_q;

  // Levels that feed the debounce counters: the keys, plus the switches
  // when they are debounced too.
  logic [N_DB-1:0] db_level;
`ifdef SWITCH_DEBOUNCE_EN
  assign db_level = {sw_sync_q, key_level};
`else
  assign db_level = key_level;
`endif

  // ---------------------------------------------------------------------------
  // Per-bit debounce.
  // STABLE: the level equals the debounced value, and the counter sits at 0.
  // COUNTING: the level differs, and the counter advances once per cycle.
  // If the level reverts at any point, the counter restarts from 0.
  // When the counter reaches CNT_LAST with the level still different, the
  // debounced bit takes the new level and the counter returns to 0.
  // The counter therefore never goes past CNT_LAST.
  // ---------------------------------------------------------------------------
  logic [N_DB-1:0]  db_cur;    // debounced register outputs
  logic [N_KEY-1:0] key_rise;  // debounced key about to go 0 -> 1

  genvar gi;
  generate
    for (gi = 0; gi < N_DB; gi++) begin : g_db
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             bit_q, bit_d;

      always_comb begin
        cnt_d = cnt_q;
        bit_d = bit_q;
        if (db_level[gi] == bit_q) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          bit_d = db_level[gi];
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
          cnt_q <= '0;
          bit_q <= 1'b0;
        end else begin
          cnt_q <= cnt_d;
          bit_q <= bit_d;
        end
      end

      assign db_cur[gi] = bit_q;

      // Only the key bits produce press pulses.
      if (gi < N_KEY) begin : g_rise
        assign key_rise[gi] = bit_d & ~bit_q;
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Press pulse and sticky press flag.
  // The pulse register loads on the same edge as the debounced bit. The pulse
  // is therefore high in exactly the first cycle that the button reads
  // pressed. The flag is set from the registered pulse, so it rises one cycle
  // later. When a set and a clear arrive together, the set wins.
  // ---------------------------------------------------------------------------
  logic [N_KEY-1:0] press_pulse_q, press_pulse_d;
  logic [N_KEY-1:0] press_event_q, press_event_d;

  always_comb begin
    press_pulse_d = key_rise;
    press_event_d = (press_event_q & ~event_clear) | press_pulse_q;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      press_pulse_q <= '0;
      press_event_q <= '0;
    end else begin
      press_pulse_q <= press_pulse_d;
      press_event_q <= press_event_d;
    end
  end

  assign pushbuttons_export = db_cur[N_KEY-1:0];
  assign press_pulse        = press_pulse_q;
  assign press_event        = press_event_q;

`ifdef SWITCH_DEBOUNCE_EN
  assign switches_export = db_cur[N_DB-1:N_KEY];
`else
  assign switches_export = sw_sync_q;
`endif

endmodule

// File: tb/tb_input_conditioner.sv
`timescale 1ns/1ps
module tb_input_conditioner;

  localparam int DEB = 4;
  localparam int CW  = 3;
`ifdef SWITCH_DEBOUNCE_EN
  localparam int SW_LAT = DEB + 1;   // edges after edge k
`else
  localparam int SW_LAT = 1;
`endif

  localparam int SEL_KEY   = 0;
  localparam int SEL_SW    = 1;
  localparam int SEL_PULSE = 2;
  localparam int SEL_EVT   = 3;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] key_raw;
  logic [9:0] sw_raw;
  logic [3:0] event_clear;
  logic [3:0] pushbuttons_export;
  logic [9:0] switches_export;
  logic [3:0] press_pulse;
  logic [3:0] press_event;

  input_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (CW),
    .KEY_ACTIVE_LOW (1'b1)
  ) dut (
    .clk_clk           (clk),
    .reset_reset_n     (reset_n),
    .key_raw           (key_raw),
    .sw_raw            (sw_raw),
    .event_clear       (event_clear),
    .pushbuttons_export(pushbuttons_export),
    .switches_export   (switches_export),
    .press_pulse       (press_pulse),
    .press_event       (press_event)
  );

  always #5 clk = ~clk;

  // Posedge counter. Stimulus changes on a negedge when cyc == c, so that
  // edge k is c+1.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    int         due;
    int         sel;
    logic [9:0] mask;
    logic [9:0] val;
    string      name;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    string      name;
    logic [3:0] mask;
    int         low_len;
    bit         accept;
  } vec_t;

  vec_t vecs[6];

  function automatic logic [9:0] pick(int sel);
    case (sel)
      SEL_KEY:   pick = {6'b0, pushbuttons_export};
      SEL_SW:    pick = switches_export;
      SEL_PULSE: pick = {6'b0, press_pulse};
      default:   pick = {6'b0, press_event};
    endcase
  endfunction

  // Schedule a masked check "off" posedges from now.
  task automatic push_exp(int sel, logic [9:0] mask, logic [9:0] val, int off, string name);
    exp_t e;
    e.due  = cyc + off;
    e.sel  = sel;
    e.mask = mask;
    e.val  = val & mask;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic check(string name, logic [9:0] act, logic [9:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, want 0x%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard consumer: compare every entry that falls due on this cycle.
  always @(negedge clk) begin
    logic [9:0] act;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        act = pick(sb[i].sel) & sb[i].mask;
        n_cmp++;
        if (act !== sb[i].val) begin
          n_fail++;
          $display("FAIL %s: cyc %0d got 0x%h, want 0x%h", sb[i].name, cyc, act, sb[i].val);
        end
        sb.delete(i);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int rise;
    int pulses;
    int key0_bad;
    logic [3:0] m;
    logic [3:0] pv;
    logic [3:0] uv;
    logic [3:0] ev;

    // ---------------- reset with random pins ----------------
    reset_n     = 1'b0;
    key_raw     = 4'($urandom);
    sw_raw      = 10'($urandom);
    event_clear = 4'($urandom);
    repeat (3) begin
      @(negedge clk);
      key_raw = 4'($urandom);
      sw_raw  = 10'($urandom);
    end
    check("reset_keys",  {6'b0, pushbuttons_export}, 10'h000);
    check("reset_sw",    switches_export,            10'h000);
    check("reset_pulse", {6'b0, press_pulse},        10'h000);
    check("reset_event", {6'b0, press_event},        10'h000);

    key_raw     = 4'hF;
    sw_raw      = 10'h000;
    event_clear = 4'h0;
    reset_n     = 1'b1;
    $display("txn: release reset with keys idle");
    for (int t = 1; t <= 20; t++) begin
      push_exp(SEL_KEY,   10'h00F, 10'h000, t, "idle_keys");
      push_exp(SEL_SW,    10'h3FF, 10'h000, t, "idle_sw");
      push_exp(SEL_PULSE, 10'h00F, 10'h000, t, "idle_pulse");
      push_exp(SEL_EVT,   10'h00F, 10'h000, t, "idle_event");
    end
    repeat (22) @(negedge clk);

    // ---------------- table-driven key presses / glitches ----------------
    vecs[0] = '{"key0_press",     4'b0001, 8, 1'b1};
    vecs[1] = '{"key1_glitch1",   4'b0010, 1, 1'b0};
    vecs[2] = '{"key1_glitch3",   4'b0010, 3, 1'b0};
    vecs[3] = '{"key1_glitch4",   4'b0010, 4, 1'b1};
    vecs[4] = '{"key2_glitch2",   4'b0100, 2, 1'b0};
    vecs[5] = '{"key03_together", 4'b1001, 5, 1'b1};

    for (int v = 0; v < 6; v++) begin
      event_clear = 4'hF;
      push_exp(SEL_EVT, 10'h00F, 10'h000, 1, "pre_clear_event");
      @(negedge clk);
      event_clear = 4'h0;

      // Keys go low for edges k .. k+low_len-1 (k = next posedge).
      m = vecs[v].mask;
      $display("txn: %s low for %0d cycles", vecs[v].name, vecs[v].low_len);
      key_raw = 4'hF & ~m;
      for (int t = 1; t <= vecs[v].low_len + 9; t++) begin
        pv = (vecs[v].accept && t >= DEB + 1 && t < vecs[v].low_len + DEB + 1) ? m : 4'h0;
        uv = (vecs[v].accept && t == DEB + 1) ? m : 4'h0;
        ev = (vecs[v].accept && t >= DEB + 2) ? m : 4'h0;
        push_exp(SEL_KEY,   10'h00F, {6'b0, pv}, t + 1, {vecs[v].name, "_state"});
        push_exp(SEL_PULSE, 10'h00F, {6'b0, uv}, t + 1, {vecs[v].name, "_pulse"});
        push_exp(SEL_EVT,   10'h00F, {6'b0, ev}, t + 1, {vecs[v].name, "_event"});
      end
      repeat (vecs[v].low_len) @(negedge clk);
      key_raw = 4'hF;
      repeat (12) @(negedge clk);
    end

    // ---------------- event clear corner cases ----------------
    // Flags now hold 4'b1001. Clear bits 0 and 1 (bit 1 is already 0).
    $display("txn: event_clear 0011 with flags 1001");
    event_clear = 4'b0011;
    push_exp(SEL_EVT, 10'h00F, 10'h008, 1, "clear_evt0");
    push_exp(SEL_EVT, 10'h00F, 10'h008, 2, "clear_evt0_hold");
    @(negedge clk);
    event_clear = 4'h0;
    repeat (3) @(negedge clk);

    // Clear arriving in the same cycle as press_pulse[2]: the set wins.
    $display("txn: key2 press with event_clear during pulse");
    key_raw = 4'b1011;
    repeat (DEB + 2) @(negedge clk);
    check("pulse2_visible", {6'b0, press_pulse}, 10'h004);
    event_clear = 4'b0100;
    push_exp(SEL_EVT,   10'h004, 10'h004, 1, "evt2_set_beats_clear");
    push_exp(SEL_EVT,   10'h004, 10'h004, 2, "evt2_stays");
    push_exp(SEL_PULSE, 10'h00F, 10'h000, 1, "pulse2_single");
    @(negedge clk);
    event_clear = 4'h0;
    @(negedge clk);
    key_raw = 4'hF;
    repeat (10) @(negedge clk);
    event_clear = 4'hF;
    push_exp(SEL_EVT, 10'h00F, 10'h000, 1, "clear_all");
    @(negedge clk);
    event_clear = 4'h0;
    repeat (2) @(negedge clk);

    // ---------------- switches ----------------
    $display("txn: sw_raw[9] rises, latency %0d edges", SW_LAT);
    sw_raw = 10'h200;
    push_exp(SEL_SW, 10'h3FF, 10'h000, SW_LAT,     "sw9_before");
    push_exp(SEL_SW, 10'h3FF, 10'h200, SW_LAT + 1, "sw9_arrive");
    push_exp(SEL_SW, 10'h3FF, 10'h200, SW_LAT + 3, "sw9_hold");
    repeat (SW_LAT + 5) @(negedge clk);

    $display("txn: one-cycle glitch on sw_raw[0]");
    sw_raw = 10'h201;
`ifdef SWITCH_DEBOUNCE_EN
    for (int t = 1; t <= 8; t++) push_exp(SEL_SW, 10'h3FF, 10'h200, t, "sw0_glitch_reject");
`else
    push_exp(SEL_SW, 10'h3FF, 10'h200, 1, "sw0_glitch_pre");
    push_exp(SEL_SW, 10'h3FF, 10'h201, 2, "sw0_glitch_pass");
    push_exp(SEL_SW, 10'h3FF, 10'h200, 3, "sw0_glitch_post");
`endif
    @(negedge clk);
    sw_raw = 10'h200;
    repeat (10) @(negedge clk);

    // ---------------- reset in the middle of a count ----------------
    $display("txn: key0 pressed, key3 counting, then reset");
    key_raw = 4'b1110;
    repeat (DEB + 4) @(negedge clk);
    check("pre_reset_key0", {6'b0, pushbuttons_export}, 10'h001);
    check("pre_reset_evt0", {6'b0, press_event},        10'h001);
    key_raw = 4'b0110;
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_keys",  {6'b0, pushbuttons_export}, 10'h000);
    check("async_reset_event", {6'b0, press_event},        10'h000);
    check("async_reset_sw",    switches_export,            10'h000);
    check("async_reset_pulse", {6'b0, press_pulse},        10'h000);
    @(negedge clk);
    key_raw = 4'b0111;
    @(negedge clk);
    reset_n  = 1'b1;
    rise     = -1;
    pulses   = 0;
    key0_bad = 0;
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      if (pushbuttons_export[3] && rise < 0) rise = j;
      if (press_pulse[3]) pulses++;
      if (pushbuttons_export[0]) key0_bad++;
    end
    $display("txn: key3 rose %0d cycles after reset release, %0d pulse(s)", rise, pulses);
    // A held key needs a full qualification: at least DEB edges and at most
    // DEB plus the synchronizer depth.
    check("key3_requalify_window", {9'b0, (rise >= DEB && rise <= DEB + 2)}, 10'h001);
    check("key3_single_pulse",     10'(pulses),                             10'h001);
    check("key0_no_false_press",   10'(key0_bad),                           10'h000);
    check("evt_after_reset",       {6'b0, press_event},                     10'h008);
    key_raw = 4'hF;
    repeat (10) @(negedge clk);

    check("scoreboard_drained", 10'(sb.size()), 10'h000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
